// File: rtl/thiele_coproc_arbiter.sv
// Round-robin arbiter sharing one coprocessor channel between the logic-engine and
// Python-exec ports: one transaction in flight, per-transaction timeout, grant counters.
module thiele_coproc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             logic_req,
  input  logic [31:0]      logic_addr,
  output logic             logic_ack,
  output logic [31:0]      logic_data,
  input  logic             py_req,
  input  logic [31:0]      py_code_addr,
  output logic             py_ack,
  output logic [31:0]      py_result,
  output logic             cop_req,
  output logic             cop_sel,
  output logic [31:0]      cop_addr,
  input  logic             cop_ack,
  input  logic [31:0]      cop_data,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clear,
  output logic [CNT_W-1:0] logic_grants,
  output logic [CNT_W-1:0] py_grants
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic               last_sel_q, last_sel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               cop_req_q, cop_req_d;
  logic               cop_sel_q, cop_sel_d;
  logic [31:0]        cop_addr_q, cop_addr_d;
  logic               logic_ack_q, logic_ack_d;
  logic               py_ack_q, py_ack_d;
  logic [31:0]        logic_data_q, logic_data_d;
  logic [31:0]        py_result_q, py_result_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   logic_grants_q, logic_grants_d;
  logic [CNT_W-1:0]   py_grants_q, py_grants_d;
  logic               rsp_valid;
  logic               tmo_hit;
  logic [31:0]        rsp_data;

  always_comb begin
    state_d        = state_q;
    last_sel_d     = last_sel_q;
    timer_d        = timer_q;
    cop_req_d      = cop_req_q;
    cop_sel_d      = cop_sel_q;
    cop_addr_d     = cop_addr_q;
    logic_ack_d    = 1'b0;
    py_ack_d       = 1'b0;
    logic_data_d   = logic_data_q;
    py_result_d    = py_result_q;
    logic_grants_d = logic_grants_q;
    py_grants_d    = py_grants_q;
    rsp_valid      = 1'b0;
    tmo_hit        = 1'b0;
    rsp_data       = '0;

    case (state_q)
      S_IDLE: begin
        if (logic_req || py_req) begin
          // On a tie the requester not served last wins
          cop_sel_d  = (logic_req && py_req) ? ~last_sel_q : py_req;
          cop_addr_d = cop_sel_d ? py_code_addr : logic_addr;
          cop_req_d  = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cop_ack) begin
          rsp_valid = 1'b1;
          rsp_data  = cop_data;
        end else if (TMO_EN && timer_q == TMR_LAST) begin
          rsp_valid = 1'b1;
          rsp_data  = ERR_DATA;
          tmo_hit   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        last_sel_d = cop_sel_q;
        if (cop_sel_q) begin
          if (py_grants_q != '1) py_grants_d = py_grants_q + 1'b1;
        end else begin
          if (logic_grants_q != '1) logic_grants_d = logic_grants_q + 1'b1;
        end
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!(cop_sel_q ? py_req : logic_req)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rsp_valid) begin
      cop_req_d = 1'b0;
      state_d   = S_RESP;
      if (cop_sel_q) begin
        py_ack_d    = 1'b1;
        py_result_d = rsp_data;
      end else begin
        logic_ack_d  = 1'b1;
        logic_data_d = rsp_data;
      end
    end

    // A timeout in the same cycle as err_clear keeps the flag set
    timeout_err_d = (timeout_err_q & ~err_clear) | tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_sel_q     <= 1'b1;
      timer_q        <= '0;
      cop_req_q      <= 1'b0;
      cop_sel_q      <= 1'b0;
      cop_addr_q     <= '0;
      logic_ack_q    <= 1'b0;
      py_ack_q       <= 1'b0;
      logic_data_q   <= '0;
      py_result_q    <= '0;
      timeout_err_q  <= 1'b0;
      logic_grants_q <= '0;
      py_grants_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_sel_q     <= last_sel_d;
      timer_q        <= timer_d;
      cop_req_q      <= cop_req_d;
      cop_sel_q      <= cop_sel_d;
      cop_addr_q     <= cop_addr_d;
      logic_ack_q    <= logic_ack_d;
      py_ack_q       <= py_ack_d;
      logic_data_q   <= logic_data_d;
      py_result_q    <= py_result_d;
      timeout_err_q  <= timeout_err_d;
      logic_grants_q <= logic_grants_d;
      py_grants_q    <= py_grants_d;
    end
  end

  assign logic_ack    = logic_ack_q;
  assign logic_data   = logic_data_q;
  assign py_ack       = py_ack_q;
  assign py_result    = py_result_q;
  assign cop_req      = cop_req_q;
  assign cop_sel      = cop_sel_q;
  assign cop_addr     = cop_addr_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_err  = timeout_err_q;
  assign logic_grants = logic_grants_q;
  assign py_grants    = py_grants_q;

endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// Bench for thiele_coproc_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model of the arbitration rules.
module tb_thiele_coproc_arbiter;

  localparam int          TO  = 16;
  localparam int          CW  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          logic_req = 1'b0;
  logic [31:0]   logic_addr = '0;
  logic          py_req = 1'b0;
  logic [31:0]   py_code_addr = '0;
  logic          cop_ack = 1'b0;
  logic [31:0]   cop_data = '0;
  logic          err_clear = 1'b0;
  logic          logic_ack, py_ack, cop_req, cop_sel, busy, timeout_err;
  logic [31:0]   logic_data, py_result, cop_addr;
  logic [CW-1:0] logic_grants, py_grants;

  thiele_coproc_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack), .logic_data(logic_data),
    .py_req(py_req), .py_code_addr(py_code_addr), .py_ack(py_ack), .py_result(py_result),
    .cop_req(cop_req), .cop_sel(cop_sel), .cop_addr(cop_addr), .cop_ack(cop_ack), .cop_data(cop_data),
    .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear),
    .logic_grants(logic_grants), .py_grants(py_grants)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;
  int req_cycles = 0;
  int n_txn = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the channel and which phase of its transaction we are in
  int          owner;        // -1 = channel free, 0 = logic, 1 = python
  int          waited;       // WAIT cycles already spent without completion
  int          last_srv;
  bit          m_wait, m_resp, m_drain;
  logic        e_cop_req, e_sel, e_lack, e_pack, e_terr;
  logic [31:0] e_addr, e_ldata, e_pres;
  int          e_lg, e_pg;

  function automatic void model_reset();
    owner = -1; waited = 0; last_srv = 1;
    m_wait = 0; m_resp = 0; m_drain = 0;
    e_cop_req = 0; e_sel = 0; e_lack = 0; e_pack = 0; e_terr = 0;
    e_addr = '0; e_ldata = '0; e_pres = '0; e_lg = 0; e_pg = 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  function automatic void model_edge();
    bit          done;
    bit          timed_out;
    logic [31:0] rdata;
    done = 0; timed_out = 0; rdata = '0;
    e_lack = 0; e_pack = 0;
    if (m_resp) begin
      last_srv = owner;
      if (owner == 1) e_pg = sat_inc(e_pg); else e_lg = sat_inc(e_lg);
      m_resp = 0; m_drain = 1;
    end else if (m_drain) begin
      if (!((owner == 1) ? py_req : logic_req)) begin
        m_drain = 0; owner = -1;
      end
    end else if (m_wait) begin
      if (cop_ack) begin
        done = 1; rdata = cop_data;
      end else if (TO != 0 && waited + 1 == TO) begin
        done = 1; timed_out = 1; rdata = ERR;
      end else begin
        waited++;
      end
      if (done) begin
        m_wait = 0; m_resp = 1; e_cop_req = 0;
        if (owner == 1) begin e_pack = 1; e_pres = rdata; end
        else begin e_lack = 1; e_ldata = rdata; end
        $display("txn %0d: %s addr=%h data=%h%s", n_txn, (owner == 1) ? "py" : "logic",
                 e_addr, rdata, timed_out ? " timeout" : "");
        n_txn++;
      end
    end else if (logic_req || py_req) begin
      owner = (logic_req && py_req) ? 1 - last_srv : (py_req ? 1 : 0);
      e_sel = (owner == 1);
      e_addr = (owner == 1) ? py_code_addr : logic_addr;
      e_cop_req = 1; waited = 0; m_wait = 1;
    end
    e_terr = (e_terr && !err_clear) || timed_out;
  endfunction

  task automatic check_all();
    check_eq("cop_req", cop_req, e_cop_req);
    if (e_cop_req) begin
      check_eq("cop_sel", cop_sel, e_sel);
      check_eq("cop_addr", cop_addr, e_addr);
    end
    check_eq("logic_ack", logic_ack, e_lack);
    check_eq("py_ack", py_ack, e_pack);
    check_eq("logic_data", logic_data, e_ldata);
    check_eq("py_result", py_result, e_pres);
    check_eq("busy", busy, m_wait || m_resp || m_drain);
    check_eq("timeout_err", timeout_err, e_terr);
    check_eq("logic_grants", logic_grants, e_lg);
    check_eq("py_grants", py_grants, e_pg);
  endtask

  // One clock: inputs were set at the previous falling edge; outputs checked 1ns after rising
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    check_all();
    if (cop_req === 1'b1) req_cycles++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    logic_req = 0; py_req = 0; cop_ack = 0; err_clear = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single transaction: cop_ack on WAIT cycle ack_at (0 = never)
  task automatic txn(input bit r, input logic [31:0] a, input int ack_at, input logic [31:0] d);
    if (r) begin py_req = 1; py_code_addr = a; end
    else begin logic_req = 1; logic_addr = a; end
    step();
    for (int k = 1; k <= 40 && m_wait; k++) begin
      cop_ack = (k == ack_at);
      cop_data = d;
      step();
    end
    cop_ack = 0; logic_req = 0; py_req = 0;
    step();
    step();
  endtask

  bit   rq[2];
  bit   pend[2];
  int   hold[2];
  bit   exp_order[4];
  int   g, done_l, done_p, low_l, low_p;
  logic prev_req;

  initial begin
    model_reset();
    do_reset();

    txn(0, 32'h40, 3, 32'hABCD1234);
    check_eq("t1_logic_data", logic_data, 32'hABCD1234);
    check_eq("t1_logic_grants", logic_grants, 1);
    check_eq("t1_py_grants", py_grants, 0);

    req_cycles = 0;
    txn(1, 32'h80, 0, 32'h0);
    check_eq("t3_copreq_cycles", req_cycles, TO);
    check_eq("t3_py_result", py_result, 32'hDEADBEEF);
    check_eq("t3_timeout_err", timeout_err, 1);
    err_clear = 1; step(); err_clear = 0;
    check_eq("t3_err_cleared", timeout_err, 0);

    txn(1, 32'h80, TO, 32'h12345678);
    check_eq("t4_py_result", py_result, 32'h12345678);
    check_eq("t4_no_timeout", timeout_err, 0);

    cop_ack = 1; cop_data = $urandom; step(); step(); cop_ack = 0;
    logic_req = 1; logic_addr = $urandom; step();
    py_req = 1; py_code_addr = 32'h80; cop_ack = 1; cop_data = 32'h5555AAAA; step();
    cop_ack = 0;
    repeat (5) step();
    check_eq("t6_still_busy", busy, 1);
    check_eq("t6_no_grant", cop_req, 0);
    logic_req = 0; step(); step();
    check_eq("t6_py_granted", cop_req, 1);
    check_eq("t6_py_sel", cop_sel, 1);
    cop_ack = 1; step(); cop_ack = 0; py_req = 0; step(); step();

    do_reset();
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    g = 0; done_l = 0; done_p = 0; low_l = 0; low_p = 0; prev_req = 0;
    logic_req = 1; py_req = 1;
    for (int c = 0; c < 100 && (done_l < 2 || done_p < 2); c++) begin
      cop_ack = 1; cop_data = $urandom;
      step();
      if (cop_req === 1'b1 && prev_req !== 1'b1) begin
        if (g < 4) check_eq($sformatf("t2_order%0d", g), cop_sel, exp_order[g]);
        g++;
      end
      prev_req = cop_req;
      if (e_lack) begin done_l++; logic_req = 0; low_l = 0; end
      else if (!logic_req) begin low_l++; if (low_l >= 2 && done_l < 2) logic_req = 1; end
      if (e_pack) begin done_p++; py_req = 0; low_p = 0; end
      else if (!py_req) begin low_p++; if (low_p >= 2 && done_p < 2) py_req = 1; end
    end
    cop_ack = 0; logic_req = 0; py_req = 0;
    step(); step();
    check_eq("t2_grants_seen", g, 4);
    check_eq("t2_logic_grants", logic_grants, 2);
    check_eq("t2_py_grants", py_grants, 2);

    do_reset();
    for (int r = 0; r < 2; r++) begin rq[r] = 0; pend[r] = 0; hold[r] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if ((r == 1) ? e_pack : e_lack) begin pend[r] = 0; hold[r] = $urandom_range(0, 3); end
        if (rq[r]) begin
          if (!pend[r]) begin
            if (hold[r] == 0) rq[r] = 0; else hold[r]--;
          end else if (m_wait && owner == r && $urandom_range(0, 15) == 0) begin
            rq[r] = 0;
          end
        end else if (!pend[r] && $urandom_range(0, 2) == 0) begin
          rq[r] = 1; pend[r] = 1;
        end
      end
      logic_req = rq[0]; py_req = rq[1];
      logic_addr = $urandom; py_code_addr = $urandom;
      cop_ack = ((c % 400) < 330) && ($urandom_range(0, 5) == 0);
      cop_data = $urandom;
      err_clear = ($urandom_range(0, 15) == 0);
      step();
    end

    do_reset();
    logic_req = 1; logic_addr = 32'h1234; step(); step();
    check_eq("t5_in_wait", cop_req, 1);
    do_reset();
    check_eq("t5_cop_req_dropped", cop_req, 0);
    cop_ack = 1; cop_data = $urandom; step(); step(); cop_ack = 0;
    check_eq("t5_no_logic_ack", logic_ack, 0);
    check_eq("t5_grants", logic_grants, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
